deser_fifo_param: RTL and testbench

- Parametrised successor to the team's deserializer + queue pair, merged into one single-clock block.
- Serial bits arrive one per rising edge of write_in and are assembled into WIDTH-bit words.
- Completed words are pushed into a DEPTH-entry FIFO. Words are popped one per rising edge of dequeue_in.
- Adds selectable bit order, edge-qualified strobes, sticky overflow flag and simultaneous push/pop support.

---
 rtl/deser_fifo_pkg.sv | 20 ++
 rtl/rise_edge_det.sv | 25 ++
 rtl/deser_fifo_param.sv | 147 ++++++++++++++
 tb/tb_deser_fifo_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/deser_fifo_pkg.sv
// Purpose: shared defaults, bit-order enum and length-width helper for deser_fifo_param.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package deser_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Which end of the word the first serial bit lands in.
  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int len_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Purpose: single-cycle pulse on each 0->1 transition of a level strobe.
// Latency: combinational from in_i to rise_o; history register updates every clock.
// Backpressure: none.
// Ports: clock/reset (sync, active-high), in_i level input, rise_o rise pulse.
module rise_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic in_i,
  output logic rise_o
);

  logic hist_q;

  // History resets to 1 so a strobe already high when reset drops is not a rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= in_i;
    end
  end

  assign rise_o = in_i & ~hist_q;

endmodule

// File: rtl/deser_fifo_param.sv
// Purpose: serial-to-parallel word assembler feeding a DEPTH-entry FIFO, single clock.
// Latency: len_out updates 1 cycle after the last bit's strobe rise; data_out 1 cycle after a pop rise.
// Backpressure: status_out=0 when full; bits arriving then are dropped and overflow_out sticks high.
// Ports: clock, reset (sync, active-high); data_in/write_in serial bit + strobe;
//        dequeue_in pop strobe; data_out last popped word; len_out stored word count;
//        status_out ready (not full); overflow_out sticky drop flag.
module deser_fifo_param
  import deser_fifo_pkg::DEFAULT_WIDTH, deser_fifo_pkg::DEFAULT_DEPTH,
         deser_fifo_pkg::len_bits, deser_fifo_pkg::bit_order_e;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  output logic                       status_out,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [len_bits(DEPTH)-1:0] len_out,
  output logic                       overflow_out
);

  localparam int LW = len_bits(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  localparam bit_order_e       ORDER    = (MSB_FIRST != 0) ? deser_fifo_pkg::MSB_FIRST
                                                            : deser_fifo_pkg::LSB_FIRST;
  localparam logic [LW-1:0]    FULL_LEN = LW'(DEPTH);
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);

  logic              wr_rise;
  logic              deq_rise;

  logic [WIDTH-1:0]  shift_q,   shift_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]     wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q,  rd_ptr_d;
  logic [LW-1:0]     len_q,     len_d;
  logic [WIDTH-1:0]  data_q,    data_d;
  logic              ovf_q,     ovf_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              ready;
  logic              accept;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  word_next;

  rise_edge_det u_wr_edge (
    .clock  (clock),
    .reset  (reset),
    .in_i   (write_in),
    .rise_o (wr_rise)
  );

  rise_edge_det u_deq_edge (
    .clock  (clock),
    .reset  (reset),
    .in_i   (dequeue_in),
    .rise_o (deq_rise)
  );

  // Ready is taken from the registered count, so a pop in the same cycle
  // cannot make room for a bit arriving in that cycle.
  assign ready = (len_q != FULL_LEN);

  // Shift register contents including the bit being sampled this cycle.
  assign word_next = (ORDER == deser_fifo_pkg::MSB_FIRST) ? {shift_q[WIDTH-2:0], data_in}
                                                          : {data_in, shift_q[WIDTH-1:1]};

  assign accept = wr_rise & ready;
  assign push   = accept & (bit_cnt_q == LAST_BIT);
  assign pop    = deq_rise & (len_q != '0);

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    len_d     = len_q;
    data_d    = data_q;
    ovf_d     = ovf_q;

    if (accept) begin
      shift_d   = word_next;
      bit_cnt_d = push ? '0 : bit_cnt_q + CW'(1);
    end

    if (wr_rise && !ready) begin
      ovf_d = 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    // Read happens before this edge's write lands, so a simultaneous
    // push/pop returns the old head.
    if (pop) begin
      data_d   = mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   len_d = len_q + LW'(1);
      2'b01:   len_d = len_q - LW'(1);
      default: len_d = len_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      len_q     <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      len_q     <= len_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr_q] <= word_next;
    end
  end

  assign status_out   = ready;
  assign data_out     = data_q;
  assign len_out      = len_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_deser_fifo_param.sv
// Purpose: directed self-checking bench for deser_fifo_param (MSB-first and LSB-first instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_deser_fifo_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b0;
  logic       write_in = 1'b0;
  logic       dequeue_in = 1'b0;

  logic       status_m, status_l;
  logic [7:0] dout_m, dout_l;
  logic [3:0] len_m, len_l;
  logic       ovf_m, ovf_l;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  deser_fifo_param #(.WIDTH(8), .DEPTH(8), .MSB_FIRST(1)) u_msb (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .write_in     (write_in),
    .status_out   (status_m),
    .dequeue_in   (dequeue_in),
    .data_out     (dout_m),
    .len_out      (len_m),
    .overflow_out (ovf_m)
  );

  deser_fifo_param #(.WIDTH(8), .DEPTH(8), .MSB_FIRST(0)) u_lsb (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .write_in     (write_in),
    .status_out   (status_l),
    .dequeue_in   (dequeue_in),
    .data_out     (dout_l),
    .len_out      (len_l),
    .overflow_out (ovf_l)
  );

  // All stimulus tasks start and end just after a falling edge.
  task automatic send_bit(input logic b, input int hi, input int lo);
    data_in  = b;
    write_in = 1'b1;
    repeat (hi) @(negedge clock);
    write_in = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic send_word(input logic [7:0] w, input int hi, input int lo);
    for (int i = 7; i >= 0; i--) send_bit(w[i], hi, lo);
  endtask

  task automatic pop_pulse(input int hi, input int lo);
    dequeue_in = 1'b1;
    repeat (hi) @(negedge clock);
    dequeue_in = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (dout_m !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", dout_m); end
    total++; if (len_m !== 4'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", len_m); end
    total++; if (ovf_m !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_m); end
    total++; if (status_m !== 1'b1) begin bad++; $display("FAIL reset_status got=%b exp=1", status_m); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_word();
    send_word(8'h80, 10, 10);
    total++; if (len_m !== 4'd1) begin bad++; $display("FAIL single_len got=%0d exp=1", len_m); end
    total++; if (status_m !== 1'b1) begin bad++; $display("FAIL single_status got=%b exp=1", status_m); end
    pop_pulse(10, 10);
    total++; if (dout_m !== 8'h80) begin bad++; $display("FAIL single_data got=%h exp=80", dout_m); end
    // A second word only lines up if the bit counter went back to zero.
    send_word(8'h81, 10, 10);
    pop_pulse(10, 10);
    total++; if (dout_m !== 8'h81) begin bad++; $display("FAIL single_realign got=%h exp=81", dout_m); end
  endtask

  task automatic test_fifo_order();
    do_reset();
    for (int i = 0; i < 8; i++) send_word(8'h80 + 8'(i), 2, 2);
    total++; if (len_m !== 4'd8) begin bad++; $display("FAIL order_full_len got=%0d exp=8", len_m); end
    total++; if (status_m !== 1'b0) begin bad++; $display("FAIL order_full_status got=%b exp=0", status_m); end
    for (int i = 0; i < 8; i++) begin
      pop_pulse(200, 200);
      total++;
      if (dout_m !== 8'h80 + 8'(i)) begin
        bad++; $display("FAIL order_data[%0d] got=%h exp=%h", i, dout_m, 8'h80 + 8'(i));
      end
      total++;
      if (len_m !== 4'(7 - i)) begin
        bad++; $display("FAIL order_len[%0d] got=%0d exp=%0d", i, len_m, 7 - i);
      end
    end
    pop_pulse(5, 5);
    total++; if (dout_m !== 8'h87) begin bad++; $display("FAIL empty_pop_data got=%h exp=87", dout_m); end
    total++; if (len_m !== 4'd0) begin bad++; $display("FAIL empty_pop_len got=%0d exp=0", len_m); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) send_word(8'h10 + 8'(i), 2, 2);
    total++; if (status_m !== 1'b0) begin bad++; $display("FAIL ovf_status got=%b exp=0", status_m); end
    total++; if (ovf_m !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf_m); end
    send_word(8'hFF, 2, 2);
    total++; if (ovf_m !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf_m); end
    total++; if (len_m !== 4'd8) begin bad++; $display("FAIL ovf_len got=%0d exp=8", len_m); end
    // Bit rise and pop rise together while full: bit dropped, pop happens.
    data_in    = 1'b1;
    write_in   = 1'b1;
    dequeue_in = 1'b1;
    repeat (2) @(negedge clock);
    write_in   = 1'b0;
    dequeue_in = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (len_m !== 4'd7) begin bad++; $display("FAIL fullpop_len got=%0d exp=7", len_m); end
    total++; if (dout_m !== 8'h10) begin bad++; $display("FAIL fullpop_data got=%h exp=10", dout_m); end
    send_word(8'hA5, 2, 2);
    total++; if (len_m !== 4'd8) begin bad++; $display("FAIL refill_len got=%0d exp=8", len_m); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_w;
      exp_w = (i < 7) ? 8'h11 + 8'(i) : 8'hA5;
      pop_pulse(2, 2);
      total++;
      if (dout_m !== exp_w) begin
        bad++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, dout_m, exp_w);
      end
    end
    total++; if (ovf_m !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf_m); end
  endtask

  task automatic test_reset_midword();
    send_bit(1'b1, 2, 2);
    send_bit(1'b0, 2, 2);
    send_bit(1'b1, 2, 2);
    send_bit(1'b0, 2, 2);
    send_bit(1'b1, 2, 2);
    data_in  = 1'b1;
    write_in = 1'b1;
    reset    = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    repeat (5) @(negedge clock);
    write_in = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (len_m !== 4'd0) begin bad++; $display("FAIL midrst_len got=%0d exp=0", len_m); end
    total++; if (ovf_m !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b exp=0", ovf_m); end
    total++; if (dout_m !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h exp=00", dout_m); end
    send_word(8'hC5, 2, 2);
    total++; if (len_m !== 4'd1) begin bad++; $display("FAIL midrst_word_len got=%0d exp=1", len_m); end
    pop_pulse(2, 2);
    total++; if (dout_m !== 8'hC5) begin bad++; $display("FAIL midrst_msb got=%h exp=c5", dout_m); end
    total++; if (dout_l !== 8'hA3) begin bad++; $display("FAIL midrst_lsb got=%h exp=a3", dout_l); end
  endtask

  task automatic test_lsb_first();
    do_reset();
    send_word(8'h80, 2, 2);
    total++; if (len_l !== 4'd1) begin bad++; $display("FAIL lsb_len got=%0d exp=1", len_l); end
    pop_pulse(2, 2);
    total++; if (dout_l !== 8'h01) begin bad++; $display("FAIL lsb_data got=%h exp=01", dout_l); end
    total++; if (dout_m !== 8'h80) begin bad++; $display("FAIL lsb_ref_msb got=%h exp=80", dout_m); end
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] w3;
    w3 = 8'h96;
    do_reset();
    send_word(8'h3C, 2, 2);
    send_word(8'hC3, 2, 2);
    for (int i = 7; i >= 1; i--) send_bit(w3[i], 2, 2);
    data_in    = w3[0];
    write_in   = 1'b1;
    dequeue_in = 1'b1;
    repeat (2) @(negedge clock);
    write_in   = 1'b0;
    dequeue_in = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (len_m !== 4'd2) begin bad++; $display("FAIL simul_len got=%0d exp=2", len_m); end
    total++; if (dout_m !== 8'h3C) begin bad++; $display("FAIL simul_head got=%h exp=3c", dout_m); end
    pop_pulse(2, 2);
    total++; if (dout_m !== 8'hC3) begin bad++; $display("FAIL simul_second got=%h exp=c3", dout_m); end
    pop_pulse(2, 2);
    total++; if (dout_m !== 8'h96) begin bad++; $display("FAIL simul_tail got=%h exp=96", dout_m); end
    total++; if (len_m !== 4'd0) begin bad++; $display("FAIL simul_empty got=%0d exp=0", len_m); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single_word();
    test_fifo_order();
    test_overflow();
    test_reset_midword();
    test_lsb_first();
    test_simul_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
